// File: rtl/hir_window_pkg.sv
// Shared definitions for the 3x3 sliding-window generator.
package hir_window_pkg;

    // Rows and columns in the window
    localparam int WIN_DIM = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } win_state_t;

endpackage

// File: rtl/window_line_buf.sv
// Single-row delay line built from a circular RAM and one pointer.
// dout_o is the sample written DEPTH shift beats ago. It is read from the
// slot that the current beat is about to overwrite. The RAM itself is never
// reset. Only the pointer returns to zero.
module window_line_buf #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int DEPTH         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_en_i,
    input  logic [ELEMENT_WIDTH-1:0] din_i,
    output logic [ELEMENT_WIDTH-1:0] dout_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [ELEMENT_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]         ptr_q;
    logic [PTR_W-1:0]         ptr_d;

    assign dout_o = mem_q[ptr_q];

    // Next pointer: advance on each shift beat and wrap at the last slot
    always_comb begin
        ptr_d = ptr_q;
        if (shift_en_i) begin
            if (ptr_q == PTR_LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // RAM write: the new sample replaces the one being read out
    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator for a raster-order pixel stream.
// Two line buffers hold the previous two rows. A two-column shift register
// holds the last two columns. The output window is loaded only when it is
// complete.
// Optional feature macro: HIR_WINDOW_GEN_PERF_CNT_EN adds the win_count port.
module window_gen_3x3
    import hir_window_pkg::*;
#(
    parameter int ELEMENT_WIDTH = 32,
    parameter int IMG_WIDTH     = 16,
    parameter int IMG_HEIGHT    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     t,
    input  logic                     in_valid,
    input  logic [ELEMENT_WIDTH-1:0] in_data,
    output logic                     win_valid,
    output logic [ELEMENT_WIDTH-1:0] win_data [WIN_DIM-1:0][WIN_DIM-1:0],
    output logic                     win_t,
    output logic                     frame_done
`ifdef HIR_WINDOW_GEN_PERF_CNT_EN
    ,
    output logic [31:0]              win_count
`endif
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    win_state_t               state_q;
    logic                     frame_done_q;
    logic [COL_W-1:0]         col_q;
    logic [COL_W-1:0]         col_d;
    logic [ROW_W-1:0]         row_q;
    logic [ROW_W-1:0]         row_d;
    logic                     win_valid_q;
    logic [ELEMENT_WIDTH-1:0] sr_q  [WIN_DIM-1:0][1:0];
    logic [ELEMENT_WIDTH-1:0] win_q [WIN_DIM-1:0][WIN_DIM-1:0];

    logic                     accept_s;
    logic                     start_s;
    logic                     last_pix_s;
    logic                     win_hit_s;
    logic [ELEMENT_WIDTH-1:0] lb0_out_s;
    logic [ELEMENT_WIDTH-1:0] lb1_out_s;
    logic [ELEMENT_WIDTH-1:0] col_new_s [WIN_DIM-1:0];

    assign accept_s   = (state_q == RUN) && in_valid;
    assign start_s    = (state_q == IDLE) && t;
    assign last_pix_s = accept_s && (col_q == COL_LAST) && (row_q == ROW_LAST);
    // Rows 0-1 and columns 0-1 of each row never complete a window
    assign win_hit_s  = accept_s && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    window_line_buf #(.ELEMENT_WIDTH(ELEMENT_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (accept_s),
        .din_i      (in_data),
        .dout_o     (lb0_out_s)
    );

    window_line_buf #(.ELEMENT_WIDTH(ELEMENT_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (accept_s),
        .din_i      (lb0_out_s),
        .dout_o     (lb1_out_s)
    );

    // The incoming column: oldest row at index 0, current pixel at index 2
    assign col_new_s[0] = lb1_out_s;
    assign col_new_s[1] = lb0_out_s;
    assign col_new_s[2] = in_data;

    // Raster position counters: restart on frame start, step on accepted beats
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_s) begin
            col_d = '0;
            row_d = '0;
        end else if (accept_s) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Position counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Frame FSM with registered frame_done (high exactly while in DONE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_done_q <= 1'b0;
                    if (t) begin
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (last_pix_s) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                    end else begin
                        state_q      <= RUN;
                        frame_done_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Column shift register and output window: load only when a window completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            for (int i = 0; i < WIN_DIM; i++) begin
                sr_q[i][0] <= '0;
                sr_q[i][1] <= '0;
                for (int j = 0; j < WIN_DIM; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            win_valid_q <= win_hit_s;
            if (accept_s) begin
                for (int i = 0; i < WIN_DIM; i++) begin
                    sr_q[i][0] <= sr_q[i][1];
                    sr_q[i][1] <= col_new_s[i];
                    if (win_hit_s) begin
                        win_q[i][0] <= sr_q[i][0];
                        win_q[i][1] <= sr_q[i][1];
                        win_q[i][2] <= col_new_s[i];
                    end
                end
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign win_t      = win_valid_q;
    assign frame_done = frame_done_q;
    assign win_data   = win_q;

`ifdef HIR_WINDOW_GEN_PERF_CNT_EN
    logic [31:0] win_count_q;

    // Saturating window counter, cleared when a frame starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_count_q <= 32'd0;
        end else if (start_s) begin
            win_count_q <= 32'd0;
        end else if (win_hit_s && (win_count_q != 32'hFFFF_FFFF)) begin
            win_count_q <= win_count_q + 32'd1;
        end else begin
            win_count_q <= win_count_q;
        end
    end

    assign win_count = win_count_q;
`endif

endmodule
